mem_byte_master: RTL and testbench
==================================

# mem_byte_master

Initiator-side load/store sequencer for the CPU data path. Accepts one 32-bit load or store request from the execute stage, then performs it as a series of single-byte transfers against a byte-wide, 256-byte data memory. Bytes are ordered big-endian: the most significant byte is at the lowest address. On completion it returns an aligned, size-adjusted result and a one-cycle completion pulse.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the memory side (256 bytes)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- req  in  1  request strobe; accepted only while busy=0
- RW  in  1  1 = write (store), 0 = read (load)
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign_ext  in  1  load only: 1 = sign-extend, 0 = zero-extend
- address  in  32  byte address of the access
- DataIn  in  32  store data, right-justified for byte and halfword
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done; marks a misaligned or illegal access
- DataOut  out  32  load result
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  write byte
- mem_we  out  1  byte write enable
- mem_re  out  1  byte read enable
- mem_rdata  in  8  read byte; valid the cycle after mem_re

## Operation
- States: IDLE, XFER, FINISH, ERR.
- IDLE with req=1: latch RW, size, sign_ext, address and DataIn.
  - Set N = 1, 2 or 4 from size.
  - Set byte index i = 0.
  - Go to ERR if any of these holds: size=11; size=01 with address[0]=1; size=10 with address[1:0]≠0.
  - Otherwise go to XFER.
- XFER, cycle i (0..N-1):
  - mem_addr = address[ADDR_W-1:0] + i, modulo 2^ADDR_W.
  - Write: mem_we=1, mem_re=0.
  - Read: mem_re=1, mem_we=0.
  - After cycle N-1, go to FINISH.
- Write byte i, big-endian:
  - Word: byte i = DataIn[31-8i:24-8i].
  - Half: byte 0 = DataIn[15:8], byte 1 = DataIn[7:0].
  - Byte: byte 0 = DataIn[7:0].
- Read accumulator: in each XFER cycle i≥1 and in FINISH, shift acc = {acc[23:0], mem_rdata}.
- FINISH:
  - done=1 for one cycle, then go to IDLE.
  - On a read, load DataOut from the low 8·N bits of the accumulator. Byte and half are sign- or zero-extended to 32 bits per sign_ext. A word is loaded unchanged.
  - On a write, DataOut is unchanged.
- ERR: done=1 and err=1 for one cycle. No memory enable is asserted and DataOut is unchanged. Then go to IDLE.
- busy = 1 in XFER, FINISH and ERR.
- req while busy=1 is ignored and not queued. A request can be accepted in the cycle immediately after FINISH or ERR.
- mem_we and mem_re are never high together; both are low outside XFER.
- Address bits above ADDR_W are ignored (wrap). An aligned access never crosses the top of memory.

## Timing
- Reset values: busy=0, done=0, err=0, DataOut=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0. State=IDLE, accumulator=0.
- Reset mid-operation: returns to IDLE at that edge. Enables drop at that edge, no done is issued and DataOut is cleared.
- Request accepted at edge T:
  - XFER occupies cycles T+1..T+N.
  - done is high in cycle T+N+1.
  - DataOut is valid from T+N+1 and holds until the next read completes.
- Latency from accepting edge to done: byte 2, half 3, word 5 cycles. Error accesses: 1 cycle.
- mem_rdata is sampled exactly one cycle after the matching mem_re.

## Test plan
- Reset, then word store 0x12345678 to address 0x10 → mem_we at 0x10..0x13 with data 12,34,56,78 on four consecutive cycles; done 5 cycles after accept; err=0.
- Word load from 0x10 (memory model holding the bytes above) → DataOut=0x12345678 in the done cycle; mem_re high for exactly 4 cycles.
- Byte load 0x80 at 0x21: sign_ext=1 → 0xFFFFFF80; sign_ext=0 → 0x00000080. Half load at 0x22 holding 80,01 with sign_ext=1 → 0xFFFF8001.
- Misaligned cases: word at 0x11, half at 0x23, size=11 → done and err one cycle after accept; no mem_we or mem_re; DataOut unchanged.
- Assert req continuously during a word load → second request accepted only the cycle after done; store at address 0x1FC with ADDR_W=8 → mem_addr 0xFC..0xFF.
- Assert Reset in the third XFER cycle of a word store → enables low next cycle, no done, DataOut=0; a new request afterwards completes normally.

Source files
------------

// File: rtl/mem_byte_master.sv
// Load/store sequencer: turns one 32-bit request into big-endian single-byte transfers
// against a byte-wide memory and returns a size-adjusted load result.
module mem_byte_master #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic              RW,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       address,
  input  logic [31:0]       DataIn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       DataOut,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {StIdle, StXfer, StFinish, StErr} state_t;

  state_t            r_state;
  logic              r_rw;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_idx;
  logic [1:0]        r_last;
  logic [31:0]       r_wdata;
  logic [31:0]       r_acc;
  logic [31:0]       r_dout;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;

  logic              w_illegal;
  logic [1:0]        w_last;
  logic [31:0]       w_wdata_aligned;
  logic [31:0]       w_acc_next;
  logic [31:0]       w_load_result;

  always_comb begin
    w_illegal = 1'b0;
    w_last    = 2'd0;
    w_wdata_aligned = DataIn;
    unique case (size)
      2'b00: begin
        w_last          = 2'd0;
        w_wdata_aligned = {DataIn[7:0], 24'h000000};
      end
      2'b01: begin
        w_last          = 2'd1;
        w_wdata_aligned = {DataIn[15:0], 16'h0000};
        w_illegal       = address[0];
      end
      2'b10: begin
        w_last          = 2'd3;
        w_wdata_aligned = DataIn;
        w_illegal       = (address[1:0] != 2'b00);
      end
      default: begin
        w_last          = 2'd0;
        w_wdata_aligned = DataIn;
        w_illegal       = 1'b1;
      end
    endcase
  end

  // The last read byte arrives during FINISH, so the result is formed from the
  // accumulator plus the live read byte and shown combinationally that cycle.
  assign w_acc_next = {r_acc[23:0], mem_rdata};

  always_comb begin
    w_load_result = w_acc_next;
    unique case (r_size)
      2'b00: w_load_result = {{24{r_sext & w_acc_next[7]}}, w_acc_next[7:0]};
      2'b01: w_load_result = {{16{r_sext & w_acc_next[15]}}, w_acc_next[15:0]};
      default: w_load_result = w_acc_next;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_rw        <= 1'b0;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_wdata     <= 32'h0;
      r_acc       <= 32'h0;
      r_dout      <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (req) begin
            r_rw   <= RW;
            r_size <= size;
            r_sext <= sign_ext;
            r_idx  <= 2'd0;
            r_last <= w_last;
            if (w_illegal) begin
              r_state <= StErr;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= StXfer;
              r_mem_addr  <= address[ADDR_W-1:0];
              r_mem_we    <= RW;
              r_mem_re    <= ~RW;
              r_mem_wdata <= w_wdata_aligned[31:24];
              r_wdata     <= {w_wdata_aligned[23:0], 8'h00};
            end
          end
        end
        StXfer: begin
          if (!r_rw && (r_idx != 2'd0)) r_acc <= w_acc_next;
          if (r_idx == r_last) begin
            r_state  <= StFinish;
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_idx       <= r_idx + 2'd1;
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            r_mem_wdata <= r_wdata[31:24];
            r_wdata     <= {r_wdata[23:0], 8'h00};
          end
        end
        StFinish: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
          if (!r_rw) begin
            r_acc  <= w_acc_next;
            r_dout <= w_load_result;
          end
        end
        StErr: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = (r_state != StIdle);
  assign done      = r_done;
  assign err       = r_err;
  assign DataOut   = ((r_state == StFinish) && !r_rw) ? w_load_result : r_dout;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_mem_byte_master.sv
// Scoreboard bench for mem_byte_master: a byte-array reference model predicts bus
// transfers and completions; a monitor compares them as the DUT presents them.
module tb_mem_byte_master;

  localparam int unsigned AW = 8;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          req;
  logic          RW;
  logic [1:0]    size;
  logic          sign_ext;
  logic [31:0]   address;
  logic [31:0]   DataIn;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   DataOut;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;

  mem_byte_master #(.ADDR_W(AW)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .req      (req),
    .RW       (RW),
    .size     (size),
    .sign_ext (sign_ext),
    .address  (address),
    .DataIn   (DataIn),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .DataOut  (DataOut),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        err;
    logic [31:0] dout;
    int unsigned acc_cyc;
    int unsigned lat;
  } done_t;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  data;
    int unsigned cyc;
  } bus_t;

  done_t       exp_q[$];
  bus_t        bus_q[$];
  logic [7:0]  ref_mem[256];
  logic [7:0]  bmem[256];
  logic [31:0] ref_dout;
  logic        mem_load;
  logic        mon_on;
  int unsigned ncyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge CLK) ncyc <= ncyc + 1;

  // Synchronous byte memory: read data appears the cycle after mem_re.
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) bmem[i] <= ref_mem[i];
    end else if (mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= bmem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference model: applies the request to ref_mem and predicts bus bytes and completion.
  task automatic model(input logic rw, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] din,
                       input int unsigned acc, input int limit, input bit want_done);
    int          n;
    logic [31:0] val;
    logic [7:0]  a;
    done_t       d;
    bus_t        b;
    bit          illegal;
    illegal = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0);
    d.acc_cyc = acc;
    if (illegal) begin
      d.err  = 1'b1;
      d.dout = ref_dout;
      d.lat  = 1;
      if (want_done) exp_q.push_back(d);
      return;
    end
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    val = 32'h0;
    for (int i = 0; i < n && i < limit; i++) begin
      a      = 8'((addr + 32'(i)) % 256);
      b.addr = a;
      b.we   = rw;
      b.cyc  = acc + 1 + i;
      if (rw) begin
        b.data     = 8'((din >> (8 * (n - 1 - i))) & 32'hff);
        ref_mem[a] = b.data;
      end else begin
        b.data = 8'h00;
        val    = (val << 8) | 32'(ref_mem[a]);
      end
      bus_q.push_back(b);
    end
    if (!rw) begin
      if (n == 1 && sx && val >= 32'h80) val = val + 32'hffffff00;
      if (n == 2 && sx && val >= 32'h8000) val = val + 32'hffff0000;
      ref_dout = val;
    end
    d.err  = 1'b0;
    d.dout = ref_dout;
    d.lat  = 32'(n + 1);
    if (want_done) exp_q.push_back(d);
  endtask

  initial forever begin
    bus_t  b;
    done_t d;
    @(negedge CLK);
    if (mem_we === 1'b1 || mem_re === 1'b1) begin
      check("bus_op_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        b = bus_q.pop_front();
        check("bus_cycle", ncyc, b.cyc);
        check("bus_addr", 32'(mem_addr), 32'(b.addr));
        check("bus_we", 32'(mem_we), 32'(b.we));
        check("bus_re", 32'(mem_re), 32'(!b.we));
        if (b.we) check("bus_wdata", 32'(mem_wdata), 32'(b.data));
      end
    end
    if (done === 1'b1) begin
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        check("err", 32'(err), 32'(d.err));
        check("dataout", DataOut, d.dout);
        check("latency", ncyc - d.acc_cyc, d.lat);
      end
    end else if (mon_on && exp_q.size() == 0 && bus_q.size() == 0) begin
      check("dataout_hold", DataOut, ref_dout);
      check("err_idle", 32'(err), 32'd0);
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && bus_q.size() == 0) break;
      @(negedge CLK);
    end
    check("drain", 32'(exp_q.size() + bus_q.size()), 32'd0);
    exp_q.delete();
    bus_q.delete();
    @(negedge CLK);
  endtask

  task automatic drive(input logic rw, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] din);
    RW       = rw;
    size     = sz;
    sign_ext = sx;
    address  = addr;
    DataIn   = din;
  endtask

  task automatic issue(input logic rw, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] din);
    @(negedge CLK);
    drive(rw, sz, sx, addr, din);
    req = 1'b1;
    model(rw, sz, sx, addr, din, ncyc, 4, 1'b1);
    @(negedge CLK);
    req = 1'b0;
    drive(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    wait_idle();
    repeat ($urandom % 2) @(negedge CLK);
  endtask

  initial begin
    int unsigned a;
    logic [1:0]  sz;
    logic [31:0] ad;
    Reset    = 1'b1;
    req      = 1'b0;
    mem_load = 1'b1;
    mon_on   = 1'b0;
    ref_dout = 32'h0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    mem_load = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dataout", DataOut, 32'h0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    Reset = 1'b0;
    @(negedge CLK);
    mon_on = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000AB80);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h5A5A8001);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'hABCD0022, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h23, 32'hFFFF);
    issue(1'b0, 2'd3, 1'b1, 32'h20, 32'h0);

    // req held through a word load: the next request lands the cycle after done.
    @(negedge CLK);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req = 1'b1;
    a   = ncyc;
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a, 4, 1'b1);
    @(negedge CLK);
    drive(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    model(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, a + 6, 4, 1'b1);
    for (int k = 0; k < 20 && ncyc < a + 6; k++) @(negedge CLK);
    @(negedge CLK);
    req = 1'b0;
    wait_idle();

    issue(1'b1, 2'd2, 1'b0, 32'h1FC, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0);

    for (int t = 0; t < 150; t++) begin
      sz = ($urandom % 8 == 7) ? 2'd3 : 2'($urandom % 3);
      ad = $urandom;
      if ($urandom % 2 == 0) ad = {24'h0, 8'h40 + 8'($urandom % 32)};
      if ($urandom % 5 != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), ad, $urandom);
    end

    // Reset during the third transfer cycle of a word store.
    @(negedge CLK);
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEBABE);
    req = 1'b1;
    a   = ncyc;
    model(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEBABE, a, 3, 1'b0);
    @(negedge CLK);
    req = 1'b0;
    for (int k = 0; k < 20 && ncyc < a + 3; k++) @(negedge CLK);
    mon_on = 1'b0;
    Reset  = 1'b1;
    @(negedge CLK);
    Reset    = 1'b0;
    ref_dout = 32'h0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_re", 32'(mem_re), 32'd0);
    check("midrst_dataout", DataOut, 32'h0);
    check("midrst_bytes", 32'(bus_q.size()), 32'd0);
    mon_on = 1'b1;
    repeat (3) @(negedge CLK);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h7F, 32'h5C);
    issue(1'b0, 2'd0, 1'b1, 32'h7F, 32'h0);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
